// File: rtl/timer_pkg.sv
// timer_pkg: register offsets, TCR field layout and shared types for the
// 64-bit system timer (timer_counter and timer_prescaler).
package timer_pkg;

   // Register offsets relative to the timer window base
   localparam logic [31:0] OFF_TCR   = 32'h0000_0000;
   localparam logic [31:0] OFF_TDR0  = 32'h0000_0004;
   localparam logic [31:0] OFF_TDR1  = 32'h0000_0008;
   localparam logic [31:0] OFF_TCMP0 = 32'h0000_000C;
   localparam logic [31:0] OFF_TCMP1 = 32'h0000_0010;
   localparam logic [31:0] OFF_TIER  = 32'h0000_0014;
   localparam logic [31:0] OFF_TISR  = 32'h0000_0018;

   // TCR field positions
   localparam int TCR_EN_BIT  = 0;
   localparam int TCR_DIV_LSB = 8;
   localparam int TCR_DIV_W   = 4;

   // Largest legal prescaler exponent unless overridden at the top
   localparam int DIV_MAX_DEF = 8;

   typedef struct packed {
      logic [TCR_DIV_W-1:0] div_val;
      logic                 timer_en;
   } tcr_t;

   // Place the TCR fields into their bus-visible positions; other bits read 0
   function automatic logic [31:0] tcr_to_word(input tcr_t t);
      logic [31:0] w;
      w = 32'h0000_0000;
      w[TCR_DIV_LSB +: TCR_DIV_W] = t.div_val;
      w[TCR_EN_BIT]               = t.timer_en;
      return w;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: emits one tick every 2^div_val enabled cycles.
// clr restarts the phase from zero and suppresses the tick that cycle.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int DIV_MAX = DIV_MAX_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [TCR_DIV_W-1:0] div_val,
   input  logic                 clr,
   output logic                 tick
);

   // One spare bit so 2^DIV_MAX-1 always fits
   localparam int PW = DIV_MAX + 1;

   logic [PW-1:0] pre_q, pre_d;
   logic [PW-1:0] term_s;
   logic          tick_s;

   assign term_s = (PW'(1) << div_val) - PW'(1);
   assign tick   = tick_s;

   // Advance the phase counter and flag the terminal count
   always_comb begin
      pre_d  = pre_q;
      tick_s = 1'b0;
      if (clr) begin
         pre_d = '0;
      end else if (en) begin
         if (pre_q >= term_s) begin
            pre_d  = '0;
            tick_s = 1'b1;
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end else begin
         pre_d = pre_q;
      end
   end

   // Phase counter register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

endmodule

// File: rtl/timer_counter.sv
// timer_counter: 64-bit free-running system timer with prescaler, sticky
// compare interrupt and read-back of every register in the timer window.
// TCMP0/TCMP1 are read-only mirrors of tcmp; the compare block owns writes.
// Build option TIMER_SNAPSHOT_EN: a TDR0 read latches cnt[63:32] into a
// shadow register which TDR1 reads then return (atomic 64-bit read).
module timer_counter
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
   parameter int          DIV_MAX   = DIV_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [63:0] tcmp,
   input  logic        dbg_halt,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        rerr,
   output logic        tim_int
);

   localparam logic [TCR_DIV_W-1:0] DIV_LIMIT = TCR_DIV_W'(DIV_MAX);

   tcr_t        tcr_q, tcr_d;
   logic [63:0] cnt_q, cnt_d;
   logic        int_en_q, int_en_d;
   logic        int_st_q, int_st_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;
   logic        rerr_q, rerr_d;

   logic [31:0]          offset_s;
   logic [TCR_DIV_W-1:0] wr_div_s;
   logic                 wr_tcr_s, wr_tdr0_s, wr_tdr1_s, wr_tier_s, wr_tisr_s;
   logic                 tcr_ok_s, div_chg_s, pre_clr_s, pre_en_s, tick_s;
   logic                 cmp_hit_s;
   logic [31:0]          tdr1_rd_s;
   logic [31:0]          rd_data_s;
   logic                 rd_err_s;
   logic                 unused_wdata_s;

   assign offset_s       = addr - BASE_ADDR;
   assign wr_div_s       = wdata[TCR_DIV_LSB +: TCR_DIV_W];
   assign unused_wdata_s = ^{wdata[31:12], wdata[7:1]};

   // A TCR write with an out-of-range divider is dropped entirely
   assign tcr_ok_s  = wr_tcr_s & (wr_div_s <= DIV_LIMIT);
   assign div_chg_s = tcr_ok_s & (wr_div_s != tcr_q.div_val);
   assign pre_clr_s = ~tcr_q.timer_en | div_chg_s;
   assign pre_en_s  = tcr_q.timer_en & ~dbg_halt;
   assign cmp_hit_s = (cnt_q >= tcmp);

   timer_prescaler #(.DIV_MAX(DIV_MAX)) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .en      (pre_en_s),
      .div_val (tcr_q.div_val),
      .clr     (pre_clr_s),
      .tick    (tick_s)
   );

   // Decode which register, if any, a bus write targets
   always_comb begin
      wr_tcr_s  = 1'b0;
      wr_tdr0_s = 1'b0;
      wr_tdr1_s = 1'b0;
      wr_tier_s = 1'b0;
      wr_tisr_s = 1'b0;
      if (wr_en) begin
         case (offset_s)
            OFF_TCR:   wr_tcr_s  = 1'b1;
            OFF_TDR0:  wr_tdr0_s = 1'b1;
            OFF_TDR1:  wr_tdr1_s = 1'b1;
            OFF_TIER:  wr_tier_s = 1'b1;
            OFF_TISR:  wr_tisr_s = 1'b1;
            // compare registers are written by the compare block, not here
            OFF_TCMP0, OFF_TCMP1: wr_tcr_s = 1'b0;
            default:   wr_tcr_s  = 1'b0;
         endcase
      end else begin
         wr_tcr_s = 1'b0;
      end
   end

   // Next state for control, counter and interrupt registers
   always_comb begin
      tcr_d    = tcr_q;
      cnt_d    = cnt_q;
      int_en_d = int_en_q;
      int_st_d = int_st_q;

      if (tcr_ok_s) begin
         tcr_d.timer_en = wdata[TCR_EN_BIT];
         tcr_d.div_val  = wr_div_s;
      end else begin
         tcr_d = tcr_q;
      end

      // a half load replaces that half only and swallows the tick
      if (wr_tdr0_s) begin
         cnt_d = {cnt_q[63:32], wdata};
      end else if (wr_tdr1_s) begin
         cnt_d = {wdata, cnt_q[31:0]};
      end else if (tick_s) begin
         cnt_d = cnt_q + 64'd1;
      end else begin
         cnt_d = cnt_q;
      end

      if (wr_tier_s) begin
         int_en_d = wdata[0];
      end else begin
         int_en_d = int_en_q;
      end

      // set beats a simultaneous write-one-to-clear
      if (cmp_hit_s) begin
         int_st_d = 1'b1;
      end else if (wr_tisr_s && wdata[0]) begin
         int_st_d = 1'b0;
      end else begin
         int_st_d = int_st_q;
      end
   end

`ifdef TIMER_SNAPSHOT_EN
   logic [31:0] shadow_q, shadow_d;

   // Capture the upper count half whenever the lower half is read
   always_comb begin
      if (rd_en && (offset_s == OFF_TDR0)) begin
         shadow_d = cnt_q[63:32];
      end else begin
         shadow_d = shadow_q;
      end
   end

   // Shadow register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= 32'h0000_0000;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   assign tdr1_rd_s = shadow_q;
`else
   assign tdr1_rd_s = cnt_q[63:32];
`endif

   // Read mux over current register state; unmapped offsets flag an error
   always_comb begin
      rd_data_s = 32'h0000_0000;
      rd_err_s  = 1'b0;
      case (offset_s)
         OFF_TCR:   rd_data_s = tcr_to_word(tcr_q);
         OFF_TDR0:  rd_data_s = cnt_q[31:0];
         OFF_TDR1:  rd_data_s = tdr1_rd_s;
         OFF_TCMP0: rd_data_s = tcmp[31:0];
         OFF_TCMP1: rd_data_s = tcmp[63:32];
         OFF_TIER:  rd_data_s = {31'h0000_0000, int_en_q};
         OFF_TISR:  rd_data_s = {31'h0000_0000, int_st_q};
         default:   rd_err_s  = 1'b1;
      endcase
   end

   // Read response is produced the cycle after the strobe
   always_comb begin
      rvalid_d = rd_en;
      if (rd_en) begin
         rdata_d = rd_data_s;
         rerr_d  = rd_err_s;
      end else begin
         rdata_d = 32'h0000_0000;
         rerr_d  = 1'b0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         tcr_q    <= '0;
         cnt_q    <= 64'h0;
         int_en_q <= 1'b0;
         int_st_q <= 1'b0;
         rdata_q  <= 32'h0000_0000;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
      end else begin
         tcr_q    <= tcr_d;
         cnt_q    <= cnt_d;
         int_en_q <= int_en_d;
         int_st_q <= int_st_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
      end
   end

   assign rdata   = rdata_q;
   assign rvalid  = rvalid_q;
   assign rerr    = rerr_q;
   assign tim_int = int_st_q & int_en_q;

endmodule
